// File: rtl/core_joypad_port.sv
// Controller-port responder for $4016/$4017: OUT latch, strobe, two 4021-style shift registers.
// Latency: read data and hit are combinational; commits land on the clock edge of the phy2 fall.
// Backpressure: none on the bus side; I_ready low stalls all commits and freezes phy2 edge tracking.
//
// Ports:
//   I_clock, I_reset     system clock, async active-high reset
//   I_addr, I_rdwr,      core bus address, 1=read/0=write, write data
//   I_wr_data
//   I_phy2, I_ready      phase-2 level, core ready (no commit while low)
//   I_pad0, I_pad1       button levels, 1 = pressed, bit0 = A ... bit7 = Right
//   O_rd_data, O_hit     read-mux data {OPEN_BUS, 4'b0, serial bit} and select
//   O_out                OUT[2:0] latch from the last $4016 write
//   O_pad_clk            one-clock pulse per port on each committed read
module core_joypad_port #(
  parameter logic [15:0] BASE_ADDR = 16'h4016,
  parameter logic [2:0]  OPEN_BUS  = 3'b010
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic [15:0] I_addr,
  input  logic        I_rdwr,
  input  logic [7:0]  I_wr_data,
  input  logic        I_phy2,
  input  logic        I_ready,
  input  logic [7:0]  I_pad0,
  input  logic [7:0]  I_pad1,
  output logic [7:0]  O_rd_data,
  output logic        O_hit,
  output logic [2:0]  O_out,
  output logic [1:0]  O_pad_clk
);

  localparam logic [15:0] ADDR1 = BASE_ADDR + 16'd1;

  logic       last_phy2;
  logic       strobe;
  logic [7:0] shift0;
  logic [7:0] shift1;

  logic sel0;
  logic sel1;
  logic commit;
  logic wr_commit0;
  logic rd_commit0;
  logic rd_commit1;
  logic serial_bit;

  // Bits [7:3] of the write data have no meaning for this register.
  logic unused_wr_bits;
  assign unused_wr_bits = ^I_wr_data[7:3];

  assign sel0   = (I_addr == BASE_ADDR);
  assign sel1   = (I_addr == ADDR1);
  // Falling edge of phy2 as seen through the ready gate: the core's own commit point.
  assign commit = I_ready & last_phy2 & ~I_phy2;

  assign wr_commit0 = commit & ~I_rdwr & sel0;
  assign rd_commit0 = commit &  I_rdwr & sel0;
  assign rd_commit1 = commit &  I_rdwr & sel1;

  // Gated by reset so the read mux sees nothing from this block while it is held.
  assign O_hit      = ~I_reset & I_rdwr & (sel0 | sel1);
  assign serial_bit = sel1 ? shift1[0] : shift0[0];
  assign O_rd_data  = O_hit ? {OPEN_BUS, 4'b0000, serial_bit} : 8'h00;

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      last_phy2 <= 1'b0;
      strobe    <= 1'b0;
      shift0    <= 8'hFF;
      shift1    <= 8'hFF;
      O_out     <= 3'b000;
      O_pad_clk <= 2'b00;
    end else begin
      if (I_ready) begin
        last_phy2 <= I_phy2;
      end

      if (wr_commit0) begin
        strobe <= I_wr_data[0];
        O_out  <= I_wr_data[2:0];
      end

      // The reload uses the strobe value from before any write committing on this
      // edge, so a 1->0 write still captures the pads on its own edge. While the
      // strobe is high a read does not shift; the reload wins.
      if (strobe) begin
        shift0 <= I_pad0;
        shift1 <= I_pad1;
      end else begin
        if (rd_commit0) shift0 <= {1'b1, shift0[7:1]};
        if (rd_commit1) shift1 <= {1'b1, shift1[7:1]};
      end

      // sel0 and sel1 are exclusive, so at most one pulse is high at a time.
      O_pad_clk <= {rd_commit1, rd_commit0};
    end
  end

endmodule

// File: tb/tb_core_joypad_port.sv
module tb_core_joypad_port;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        rdwr;
  logic [7:0]  wr_data;
  logic        phy2;
  logic        ready;
  logic [7:0]  pad0;
  logic [7:0]  pad1;
  logic [7:0]  rd_data;
  logic        hit;
  logic [2:0]  out_latch;
  logic [1:0]  pad_clk;

  int checks = 0;
  int errors = 0;

  core_joypad_port dut (
    .I_clock   (clk),
    .I_reset   (rst),
    .I_addr    (addr),
    .I_rdwr    (rdwr),
    .I_wr_data (wr_data),
    .I_phy2    (phy2),
    .I_ready   (ready),
    .I_pad0    (pad0),
    .I_pad1    (pad1),
    .O_rd_data (rd_data),
    .O_hit     (hit),
    .O_out     (out_latch),
    .O_pad_clk (pad_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus read cycle: phy2 high for a clock, then low; data is checked before the
  // commit edge (pre-shift), pad_clk just after it and again one clock later.
  task automatic do_read(input string tag, input logic [15:0] a,
                         input logic [7:0] exp_d, input logic [1:0] exp_clk);
    @(negedge clk);
    addr = a; rdwr = 1'b1; phy2 = 1'b1;
    @(negedge clk);
    phy2 = 1'b0;
    #1;
    chk({tag, "_data"}, rd_data, exp_d);
    chk({tag, "_hit"}, {7'b0, hit}, 8'h01);
    @(posedge clk); #1;
    chk({tag, "_padclk"}, {6'b0, pad_clk}, {6'b0, exp_clk});
    @(posedge clk); #1;
    chk({tag, "_padclk_end"}, {6'b0, pad_clk}, 8'h00);
  endtask

  task automatic do_write(input string tag, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; rdwr = 1'b0; wr_data = d; phy2 = 1'b1;
    @(negedge clk);
    phy2 = 1'b0;
    #1;
    chk({tag, "_hit"}, {7'b0, hit}, 8'h00);
    @(posedge clk); #1;
    chk({tag, "_padclk"}, {6'b0, pad_clk}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; addr = 16'h0000; rdwr = 1'b1; wr_data = 8'h00;
    phy2 = 1'b0; ready = 1'b1; pad0 = 8'h00; pad1 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {5'b0, out_latch}, 8'h00);
    chk("rst_padclk", {6'b0, pad_clk}, 8'h00);
    addr = 16'h4016;
    #1;
    chk("rst_hit_gated", {7'b0, hit}, 8'h00);
    chk("rst_data_gated", rd_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Fresh reset: shift registers hold all ones.
    do_read("t1_read", 16'h4016, 8'h41, 2'b01);
    chk("t1_out", {5'b0, out_latch}, 8'h00);

    // Serial sequence of port 0: A,B,Sel,Start,Up,Dn,L,R then ones.
    pad0 = 8'b1000_0101;
    do_write("t2_w1", 16'h4016, 8'h01);
    chk("t2_out1", {5'b0, out_latch}, 8'h01);
    do_write("t2_w0", 16'h4016, 8'h00);
    chk("t2_out0", {5'b0, out_latch}, 8'h00);
    pad0 = 8'h00;  // already captured; live pads must not matter now
    do_read("t2_r0", 16'h4016, 8'h41, 2'b01);
    do_read("t2_r1", 16'h4016, 8'h40, 2'b01);
    do_read("t2_r2", 16'h4016, 8'h41, 2'b01);
    do_read("t2_r3", 16'h4016, 8'h40, 2'b01);
    do_read("t2_r4", 16'h4016, 8'h40, 2'b01);
    do_read("t2_r5", 16'h4016, 8'h40, 2'b01);
    do_read("t2_r6", 16'h4016, 8'h40, 2'b01);
    do_read("t2_r7", 16'h4016, 8'h41, 2'b01);
    do_read("t2_r8", 16'h4016, 8'h41, 2'b01);

    // Port 1 shifts independently of port 0.
    pad0 = 8'h00; pad1 = 8'h02;
    do_write("t3_w1", 16'h4016, 8'h01);
    do_write("t3_w0", 16'h4016, 8'h00);
    do_read("t3_r0", 16'h4017, 8'h40, 2'b10);
    do_read("t3_r1", 16'h4017, 8'h41, 2'b10);
    do_read("t3_p0", 16'h4016, 8'h40, 2'b01);

    // Strobe held: reads follow the live A button and never shift.
    do_write("t4_w1", 16'h4016, 8'h01);
    pad0 = 8'h01;
    do_read("t4_r0", 16'h4016, 8'h41, 2'b01);
    pad0 = 8'h00;
    do_read("t4_r1", 16'h4016, 8'h40, 2'b01);
    pad0 = 8'h01;
    do_read("t4_r2", 16'h4016, 8'h41, 2'b01);

    // $4017 writes belong to another block.
    do_write("t5_w7", 16'h4016, 8'h07);
    do_write("t5_w17", 16'h4017, 8'h00);
    chk("t5_out", {5'b0, out_latch}, 8'h07);
    pad0 = 8'h00;
    do_read("t5_strobe_lo", 16'h4016, 8'h40, 2'b01);
    pad0 = 8'h01;
    do_read("t5_strobe_hi", 16'h4016, 8'h41, 2'b01);

    // Ready low across the phy2 fall: no commit until ready returns.
    pad0 = 8'h02;
    do_write("t6_w0", 16'h4016, 8'h00);
    chk("t6_out", {5'b0, out_latch}, 8'h00);
    @(negedge clk);
    addr = 16'h4016; rdwr = 1'b1; phy2 = 1'b1;
    @(negedge clk);
    ready = 1'b0; phy2 = 1'b0;
    @(posedge clk); #1;
    chk("t6_stall_padclk", {6'b0, pad_clk}, 8'h00);
    @(negedge clk);
    phy2 = 1'b1;
    @(posedge clk); #1;
    chk("t6_stall_padclk2", {6'b0, pad_clk}, 8'h00);
    @(negedge clk);
    ready = 1'b1;
    do_read("t6_r0", 16'h4016, 8'h40, 2'b01);
    do_read("t6_r1", 16'h4016, 8'h41, 2'b01);

    // Reset in the middle of a read sequence.
    pad0 = 8'h00;
    do_write("t7_w7", 16'h4016, 8'h07);
    do_write("t7_w6", 16'h4016, 8'h06);
    chk("t7_out6", {5'b0, out_latch}, 8'h06);
    do_read("t7_r0", 16'h4016, 8'h40, 2'b01);
    do_read("t7_r1", 16'h4016, 8'h40, 2'b01);
    do_read("t7_r2", 16'h4016, 8'h40, 2'b01);
    @(negedge clk);
    addr = 16'h4016; rdwr = 1'b1;
    #1;
    chk("t7_hit_pre", {7'b0, hit}, 8'h01);
    rst = 1'b1;
    #1;
    chk("t7_rst_out", {5'b0, out_latch}, 8'h00);
    chk("t7_rst_padclk", {6'b0, pad_clk}, 8'h00);
    chk("t7_rst_hit", {7'b0, hit}, 8'h00);
    chk("t7_rst_data", rd_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    do_read("t7_after", 16'h4016, 8'h41, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
